vlsu_bank_scheduler: RTL and testbench
======================================

VLSU_BANK_SCHEDULER -- requirements
Module: vlsu_bank_scheduler

Interface
REQ-001 SHALL have parameter NUM_LANES, default 8: number of VLSU lanes.
REQ-002 SHALL have parameter NUM_BANKS, default 8: number of data-array banks, power of two.
REQ-003 SHALL have parameter ADDR_W, default 64: lane address width.
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 req_i  input  1  new vector request; accepted when req_i && ready_o.
REQ-007 lane_valid_i  input  NUM_LANES  active lanes of the request.
REQ-008 lane_addr_i  input  NUM_LANES*ADDR_W  packed lane addresses, lane 0 in LSBs.
REQ-009 ready_o  output  1  scheduler idle and able to accept a request.
REQ-010 issue_valid_o  output  1  a conflict-free lane round is offered to the arrays/crossbar.
REQ-011 issue_lane_mask_o  output  NUM_LANES  lanes in the offered round.
REQ-012 issue_ready_i  input  1  arrays accept the offered round.
REQ-013 resp_valid_i  input  1  arrays return the result of the accepted round.
REQ-014 resp_hit_i  input  NUM_LANES  per-lane hit of the returned round.
REQ-015 miss_req_o  output  1  refill request to the miss handler.
REQ-016 miss_lane_mask_o  output  NUM_LANES  lanes needing refill.
REQ-017 miss_done_i  input  1  miss handler finished refilling.
REQ-018 lane_done_o  output  NUM_LANES  sticky per-lane completion for the current request.
REQ-019 done_o  output  1  one-cycle pulse: request complete.
REQ-020 round_cnt_o  output  4  rounds issued for the current request, saturating at 15.
REQ-021 state_o  output  3  debug: IDLE=0, ISSUE=1, WAIT=2, MISS=3, DONE=4.

Function
REQ-022 Bank of a lane SHALL be addr[3+log2(NUM_BANKS)-1:3] (64-bit word interleave).
REQ-023 On acceptance in IDLE: capture addresses, pending_q<=lane_valid_i, miss_q<=0, lane_done_o<=0, round_cnt_o<=0; go ISSUE, or DONE if lane_valid_i==0.
REQ-024 ready_o SHALL be 1 only in IDLE; req_i outside IDLE ignored.
REQ-025 ISSUE: issue_valid_o=1; lane i in mask iff pending_q[i] and no lower-index pending lane shares its bank (lowest lane wins per bank).
REQ-026 issue_valid_o and issue_lane_mask_o SHALL hold stable until issue_ready_i; on handshake latch mask into issued_q, increment round_cnt_o (saturating), go WAIT.
REQ-027 WAIT: on resp_valid_i, for each lane in issued_q: hit -> clear pending, set lane_done_o; miss -> clear pending, set miss_q; resp_hit_i bits outside issued_q ignored.
REQ-028 WAIT exit same edge: remaining pending !=0 -> ISSUE; else miss_q !=0 -> MISS; else DONE.
REQ-029 MISS: miss_req_o=1, miss_lane_mask_o=miss_q, both held until miss_done_i; then pending_q<=miss_q, miss_q<=0, go ISSUE.
REQ-030 DONE: done_o=1 for exactly one cycle, then IDLE; lane_done_o held until next acceptance.
REQ-031 resp_valid_i outside WAIT and miss_done_i outside MISS SHALL be ignored.
REQ-032 Latency: first issue_valid_o the cycle after acceptance; done_o the cycle after final resp_valid_i.

Reset
REQ-033 rst_i asserted at any time, including mid-round or in MISS, SHALL immediately force IDLE and clear all state.
REQ-034 Reset values: ready_o=1, state_o=0, all other outputs 0.

Verification
REQ-035 8 lanes, addr=0x1000+8*i, all hit -> one issue mask 0xFF, lane_done_o=0xFF, done_o pulse, round_cnt_o=1.
REQ-036 8 lanes, addr=0x40*i (all bank 0), all hit -> 8 issues, masks 0x01,0x02,...,0x80 in order, round_cnt_o=8.
REQ-037 8 distinct banks, resp_hit_i=0xF6 -> miss_req_o with mask 0x09; after miss_done_i, reissue mask 0x09; hit -> done_o, lane_done_o=0xFF, round_cnt_o=2.
REQ-038 lane_valid_i=0x00 -> no issue_valid_o, done_o the cycle after acceptance, round_cnt_o=0.
REQ-039 issue_ready_i low 5 cycles -> issue_valid_o and mask unchanged for all 5 cycles; stray resp_valid_i in ISSUE ignored.
REQ-040 rst_i pulsed in WAIT and in MISS -> all outputs at reset values, ready_o=1; next request completes normally.

Source files
------------

// File: rtl/vlsu_bank_scheduler_if.sv
// Handshake and data bundle between the vector load/store unit front end,
// the bank scheduler, the data arrays and the miss handler.
`timescale 1ns/1ps
interface vlsu_bank_scheduler_if #(
    parameter int NUM_LANES = 8,
    parameter int ADDR_W    = 64
);
    logic                        req_i;
    logic [NUM_LANES-1:0]        lane_valid_i;
    logic [NUM_LANES*ADDR_W-1:0] lane_addr_i;
    logic                        ready_o;
    logic                        issue_valid_o;
    logic [NUM_LANES-1:0]        issue_lane_mask_o;
    logic                        issue_ready_i;
    logic                        resp_valid_i;
    logic [NUM_LANES-1:0]        resp_hit_i;
    logic                        miss_req_o;
    logic [NUM_LANES-1:0]        miss_lane_mask_o;
    logic                        miss_done_i;
    logic [NUM_LANES-1:0]        lane_done_o;
    logic                        done_o;
    logic [3:0]                  round_cnt_o;
    logic [2:0]                  state_o;

    // Requester, arrays and miss handler side (drives the scheduler inputs)
    modport master (
        output req_i, lane_valid_i, lane_addr_i, issue_ready_i,
               resp_valid_i, resp_hit_i, miss_done_i,
        input  ready_o, issue_valid_o, issue_lane_mask_o, miss_req_o,
               miss_lane_mask_o, lane_done_o, done_o, round_cnt_o, state_o
    );

    // Scheduler side
    modport slave (
        input  req_i, lane_valid_i, lane_addr_i, issue_ready_i,
               resp_valid_i, resp_hit_i, miss_done_i,
        output ready_o, issue_valid_o, issue_lane_mask_o, miss_req_o,
               miss_lane_mask_o, lane_done_o, done_o, round_cnt_o, state_o
    );
endinterface

// File: rtl/vlsu_bank_scheduler.sv
// Splits a vector memory request into bank-conflict-free lane rounds,
// tracks per-lane hits and misses, and loops through refill until every
// active lane has completed.
`timescale 1ns/1ps
module vlsu_bank_scheduler #(
    parameter int NUM_LANES = 8,
    parameter int NUM_BANKS = 8,
    parameter int ADDR_W    = 64
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    vlsu_bank_scheduler_if.slave    bus
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_MISS  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               r_state;
    logic [NUM_LANES-1:0] r_pending;
    logic [NUM_LANES-1:0] r_miss;
    logic [NUM_LANES-1:0] r_issued;
    logic [NUM_LANES-1:0] r_laneDone;
    logic [3:0]           r_roundCnt;
    logic [BANK_W-1:0]    r_bank [NUM_LANES];

    logic [NUM_LANES-1:0] w_issueMask;
    logic [NUM_LANES-1:0] w_pendingAfter;
    logic [NUM_LANES-1:0] w_missAfter;

    // Only the bank-select bits of each address matter, so only those are kept.
    // Lowest pending lane claims its bank; higher lanes on the same bank wait.
    always_comb begin
        w_issueMask = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            w_issueMask[i] = r_pending[i];
            for (int j = 0; j < i; j++) begin
                if (r_pending[j] && (r_bank[j] == r_bank[i])) begin
                    w_issueMask[i] = 1'b0;
                end
            end
        end
    end

    assign w_pendingAfter = r_pending & ~r_issued;
    assign w_missAfter    = r_miss | (r_issued & ~bus.resp_hit_i);

    assign bus.ready_o           = (r_state == S_IDLE);
    assign bus.issue_valid_o     = (r_state == S_ISSUE);
    assign bus.issue_lane_mask_o = (r_state == S_ISSUE) ? w_issueMask : '0;
    assign bus.miss_req_o        = (r_state == S_MISS);
    assign bus.miss_lane_mask_o  = (r_state == S_MISS) ? r_miss : '0;
    assign bus.lane_done_o       = r_laneDone;
    assign bus.done_o            = (r_state == S_DONE);
    assign bus.round_cnt_o       = r_roundCnt;
    assign bus.state_o           = r_state;

    // Request sequencing: accept, issue rounds, collect responses, refill misses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_pending  <= '0;
            r_miss     <= '0;
            r_issued   <= '0;
            r_laneDone <= '0;
            r_roundCnt <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_bank[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.req_i) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            r_bank[i] <= (NUM_BANKS > 1) ?
                                bus.lane_addr_i[i*ADDR_W+3 +: BANK_W] : '0;
                        end
                        r_pending  <= bus.lane_valid_i;
                        r_miss     <= '0;
                        r_laneDone <= '0;
                        r_roundCnt <= '0;
                        r_state    <= (bus.lane_valid_i == '0) ? S_DONE : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (bus.issue_ready_i) begin
                        r_issued <= w_issueMask;
                        if (r_roundCnt != 4'd15) begin
                            r_roundCnt <= r_roundCnt + 4'd1;
                        end
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.resp_valid_i) begin
                        r_pending  <= w_pendingAfter;
                        r_miss     <= w_missAfter;
                        r_laneDone <= r_laneDone | (r_issued & bus.resp_hit_i);
                        if (w_pendingAfter != '0) begin
                            r_state <= S_ISSUE;
                        end else if (w_missAfter != '0) begin
                            r_state <= S_MISS;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_MISS: begin
                    if (bus.miss_done_i) begin
                        r_pending <= r_miss;
                        r_miss    <= '0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vlsu_bank_scheduler.sv
// Self-checking bench for vlsu_bank_scheduler: directed scenarios plus
// randomized requests compared against a lane/bank reference model.
`timescale 1ns/1ps
module tb_vlsu_bank_scheduler;
    localparam int NL = 8;
    localparam int NB = 8;
    localparam int AW = 64;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    vlsu_bank_scheduler_if #(.NUM_LANES(NL), .ADDR_W(AW)) bus ();

    vlsu_bank_scheduler #(.NUM_LANES(NL), .NUM_BANKS(NB), .ADDR_W(AW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global safety net so the run always terminates
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: walk lanes upward, each pending lane takes its bank if still free
    function automatic logic [NL-1:0] model_mask(input logic [NL-1:0] pend,
                                                 input logic [NL*AW-1:0] addrs);
        bit              taken [NB];
        logic [NL-1:0]   m;
        logic [AW-1:0]   a;
        int              b;
        m = '0;
        for (int k = 0; k < NB; k++) taken[k] = 1'b0;
        for (int i = 0; i < NL; i++) begin
            a = addrs[i*AW +: AW];
            b = int'((a / 8) % NB);
            if (pend[i] && !taken[b]) begin
                m[i]     = 1'b1;
                taken[b] = 1'b1;
            end
        end
        return m;
    endfunction

    function automatic logic [NL*AW-1:0] contiguous_addrs(input logic [AW-1:0] base,
                                                          input logic [AW-1:0] stride);
        logic [NL*AW-1:0] v;
        for (int i = 0; i < NL; i++) v[i*AW +: AW] = base + stride * i;
        return v;
    endfunction

    // Runs one request end to end, acting as arrays and miss handler
    task automatic drive_request(input logic [NL-1:0]    valid,
                                 input logic [NL*AW-1:0] addrs,
                                 input logic [NL-1:0]    hitFirst,
                                 input bit               randomMode,
                                 input int               stallFirst,
                                 input bit               strayResp,
                                 input string            name);
        logic [NL-1:0] pend, missM, doneM, expMask, hitUse;
        int            rounds, respIdx, iter, stall, dly;
        pend = valid; missM = '0; doneM = '0;
        rounds = 0; respIdx = 0; iter = 0;

        @(negedge clk);
        compared++;
        if (bus.ready_o !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL %s ready_before_accept: got %b expected 1", name, bus.ready_o);
        end
        bus.req_i = 1'b1; bus.lane_valid_i = valid; bus.lane_addr_i = addrs;
        @(negedge clk);
        bus.req_i = 1'b0; bus.lane_valid_i = $urandom; bus.lane_addr_i = {16{$urandom}};

        while (pend != '0 || missM != '0) begin
            iter++;
            if (iter > 300) begin
                mismatched++;
                $display("[TB] FAIL %s round_budget: exceeded 300 iterations", name);
                break;
            end
            if (pend != '0) begin
                expMask = model_mask(pend, addrs);
                compared++;
                if ({bus.issue_valid_o, bus.state_o, bus.issue_lane_mask_o} !== {1'b1, 3'd1, expMask}) begin
                    mismatched++;
                    $display("[TB] FAIL %s issue_offer: got v=%b st=%0d m=%h expected v=1 st=1 m=%h",
                             name, bus.issue_valid_o, bus.state_o, bus.issue_lane_mask_o, expMask);
                end
                stall = (rounds == 0) ? stallFirst : (randomMode ? $urandom_range(0, 2) : 0);
                for (int s = 0; s < stall; s++) begin
                    bus.issue_ready_i = 1'b0;
                    bus.resp_valid_i  = strayResp || (randomMode && ($urandom_range(0, 1) == 1));
                    bus.resp_hit_i    = $urandom;
                    bus.miss_done_i   = randomMode && ($urandom_range(0, 1) == 1);
                    @(negedge clk);
                    bus.resp_valid_i = 1'b0; bus.miss_done_i = 1'b0;
                    compared++;
                    if ({bus.issue_valid_o, bus.issue_lane_mask_o} !== {1'b1, expMask}) begin
                        mismatched++;
                        $display("[TB] FAIL %s issue_hold[%0d]: got v=%b m=%h expected v=1 m=%h",
                                 name, s, bus.issue_valid_o, bus.issue_lane_mask_o, expMask);
                    end
                end
                bus.issue_ready_i = 1'b1;
                @(negedge clk);
                bus.issue_ready_i = 1'b0;
                rounds = (rounds >= 15) ? 15 : rounds + 1;
                compared++;
                if ({bus.issue_valid_o, bus.state_o} !== {1'b0, 3'd2}) begin
                    mismatched++;
                    $display("[TB] FAIL %s wait_entry: got v=%b st=%0d expected v=0 st=2",
                             name, bus.issue_valid_o, bus.state_o);
                end
                dly = randomMode ? $urandom_range(0, 2) : 0;
                for (int d = 0; d < dly; d++) @(negedge clk);
                hitUse = randomMode ? NL'($urandom | $urandom) : ((respIdx == 0) ? hitFirst : '1);
                bus.resp_valid_i = 1'b1;
                bus.resp_hit_i   = (hitUse & expMask) | (NL'($urandom) & ~expMask);
                @(negedge clk);
                bus.resp_valid_i = 1'b0;
                respIdx++;
                doneM = doneM | (expMask & hitUse);
                missM = missM | (expMask & ~hitUse);
                pend  = pend & ~expMask;
            end else begin
                dly = randomMode ? $urandom_range(0, 3) : 1;
                for (int d = 0; d <= dly; d++) begin
                    compared++;
                    if ({bus.miss_req_o, bus.state_o, bus.miss_lane_mask_o} !== {1'b1, 3'd3, missM}) begin
                        mismatched++;
                        $display("[TB] FAIL %s miss_req: got r=%b st=%0d m=%h expected r=1 st=3 m=%h",
                                 name, bus.miss_req_o, bus.state_o, bus.miss_lane_mask_o, missM);
                    end
                    if (d < dly) begin
                        bus.resp_valid_i = randomMode;
                        @(negedge clk);
                        bus.resp_valid_i = 1'b0;
                    end
                end
                bus.miss_done_i = 1'b1;
                @(negedge clk);
                bus.miss_done_i = 1'b0;
                pend  = missM;
                missM = '0;
            end
        end

        compared++;
        if ({bus.done_o, bus.state_o, bus.issue_valid_o} !== {1'b1, 3'd4, 1'b0}) begin
            mismatched++;
            $display("[TB] FAIL %s done_pulse: got d=%b st=%0d v=%b expected d=1 st=4 v=0",
                     name, bus.done_o, bus.state_o, bus.issue_valid_o);
        end
        compared++;
        if ({bus.lane_done_o, bus.round_cnt_o} !== {doneM, 4'(rounds)}) begin
            mismatched++;
            $display("[TB] FAIL %s completion: got lanes=%h rounds=%0d expected lanes=%h rounds=%0d",
                     name, bus.lane_done_o, bus.round_cnt_o, doneM, rounds);
        end
        @(negedge clk);
        compared++;
        if ({bus.done_o, bus.ready_o, bus.lane_done_o} !== {1'b0, 1'b1, doneM}) begin
            mismatched++;
            $display("[TB] FAIL %s after_done: got d=%b rdy=%b lanes=%h expected d=0 rdy=1 lanes=%h",
                     name, bus.done_o, bus.ready_o, bus.lane_done_o, doneM);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 1'b0; bus.lane_valid_i = '0; bus.lane_addr_i = '0;
        bus.issue_ready_i = 1'b0; bus.resp_valid_i = 1'b0; bus.resp_hit_i = '0;
        bus.miss_done_i = 1'b0;
        #12;
        compared++;
        if ({bus.ready_o, bus.state_o, bus.issue_valid_o, bus.issue_lane_mask_o, bus.miss_req_o,
             bus.miss_lane_mask_o, bus.lane_done_o, bus.done_o, bus.round_cnt_o} !== {1'b1, 34'd0}) begin
            mismatched++;
            $display("[TB] FAIL reset_values: got rdy=%b st=%0d v=%b done=%b lanes=%h rc=%0d",
                     bus.ready_o, bus.state_o, bus.issue_valid_o, bus.done_o, bus.lane_done_o, bus.round_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_contiguous();
        drive_request(8'hFF, contiguous_addrs(64'h1000, 64'd8), 8'hFF, 1'b0, 0, 1'b0, "contiguous");
        compared++;
        if ({bus.lane_done_o, bus.round_cnt_o} !== {8'hFF, 4'd1}) begin
            mismatched++;
            $display("[TB] FAIL contiguous_result: got lanes=%h rounds=%0d expected lanes=ff rounds=1",
                     bus.lane_done_o, bus.round_cnt_o);
        end
    endtask

    task automatic test_same_bank();
        drive_request(8'hFF, contiguous_addrs(64'h0, 64'h40), 8'hFF, 1'b0, 0, 1'b0, "same_bank");
        compared++;
        if ({bus.lane_done_o, bus.round_cnt_o} !== {8'hFF, 4'd8}) begin
            mismatched++;
            $display("[TB] FAIL same_bank_result: got lanes=%h rounds=%0d expected lanes=ff rounds=8",
                     bus.lane_done_o, bus.round_cnt_o);
        end
    endtask

    task automatic test_miss_refill();
        drive_request(8'hFF, contiguous_addrs(64'h1000, 64'd8), 8'hF6, 1'b0, 0, 1'b0, "miss_refill");
        compared++;
        if ({bus.lane_done_o, bus.round_cnt_o} !== {8'hFF, 4'd2}) begin
            mismatched++;
            $display("[TB] FAIL miss_refill_result: got lanes=%h rounds=%0d expected lanes=ff rounds=2",
                     bus.lane_done_o, bus.round_cnt_o);
        end
    endtask

    task automatic test_empty();
        drive_request(8'h00, contiguous_addrs(64'h2000, 64'd8), 8'hFF, 1'b0, 0, 1'b0, "empty");
        compared++;
        if ({bus.lane_done_o, bus.round_cnt_o} !== {8'h00, 4'd0}) begin
            mismatched++;
            $display("[TB] FAIL empty_result: got lanes=%h rounds=%0d expected lanes=00 rounds=0",
                     bus.lane_done_o, bus.round_cnt_o);
        end
    endtask

    task automatic test_back_pressure();
        drive_request(8'hA5, contiguous_addrs(64'h3000, 64'h20), 8'hFF, 1'b0, 5, 1'b1, "back_pressure");
    endtask

    task automatic test_reset_midflight();
        // Reset while waiting on the arrays
        @(negedge clk);
        bus.req_i = 1'b1; bus.lane_valid_i = 8'hFF;
        bus.lane_addr_i = contiguous_addrs(64'h1000, 64'd8);
        @(negedge clk);
        bus.req_i = 1'b0; bus.issue_ready_i = 1'b1;
        @(negedge clk);
        bus.issue_ready_i = 1'b0;
        compared++;
        if (bus.state_o !== 3'd2) begin
            mismatched++;
            $display("[TB] FAIL rst_wait_setup: got st=%0d expected 2", bus.state_o);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({bus.ready_o, bus.state_o, bus.issue_valid_o, bus.issue_lane_mask_o, bus.miss_req_o,
             bus.miss_lane_mask_o, bus.lane_done_o, bus.done_o, bus.round_cnt_o} !== {1'b1, 34'd0}) begin
            mismatched++;
            $display("[TB] FAIL rst_in_wait: got rdy=%b st=%0d v=%b lanes=%h rc=%0d",
                     bus.ready_o, bus.state_o, bus.issue_valid_o, bus.lane_done_o, bus.round_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        // Reset while the miss handler is busy
        bus.req_i = 1'b1;
        @(negedge clk);
        bus.req_i = 1'b0; bus.issue_ready_i = 1'b1;
        @(negedge clk);
        bus.issue_ready_i = 1'b0; bus.resp_valid_i = 1'b1; bus.resp_hit_i = 8'h00;
        @(negedge clk);
        bus.resp_valid_i = 1'b0;
        compared++;
        if ({bus.miss_req_o, bus.miss_lane_mask_o} !== {1'b1, 8'hFF}) begin
            mismatched++;
            $display("[TB] FAIL rst_miss_setup: got r=%b m=%h expected r=1 m=ff",
                     bus.miss_req_o, bus.miss_lane_mask_o);
        end
        rst = 1'b1;
        #1;
        compared++;
        if ({bus.ready_o, bus.state_o, bus.issue_valid_o, bus.issue_lane_mask_o, bus.miss_req_o,
             bus.miss_lane_mask_o, bus.lane_done_o, bus.done_o, bus.round_cnt_o} !== {1'b1, 34'd0}) begin
            mismatched++;
            $display("[TB] FAIL rst_in_miss: got rdy=%b st=%0d r=%b m=%h rc=%0d",
                     bus.ready_o, bus.state_o, bus.miss_req_o, bus.miss_lane_mask_o, bus.round_cnt_o);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_request(8'hFF, contiguous_addrs(64'h1000, 64'd8), 8'hFF, 1'b0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        logic [NL*AW-1:0] addrs;
        logic [NL-1:0]    valid;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < NL; i++) addrs[i*AW +: AW] = {$urandom, $urandom_range(0, 255)};
            valid = (r % 6 == 5) ? 8'h00 : NL'($urandom);
            drive_request(valid, addrs, 8'hFF, 1'b1, $urandom_range(0, 2), 1'b0, "random");
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_contiguous();
        test_same_bank();
        test_miss_refill();
        test_empty();
        test_back_pressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
